// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR sequencer for the RSC chip.
// Arbitrates between an instruction-fetch requester and a data (load/store)
// requester, drives the MAR/MDR select codes and memory strobes for the
// granted access, and aborts with err when memory never raises mem_ready.
//
// Build option: define MEM_ARB_RR_EN for round-robin arbitration between
// fetch and data. Left undefined, data always wins over fetch.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_req,
  output logic       fetch_ack,
  input  logic       data_req,
  input  logic       data_we,
  output logic       data_ack,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [2:0] w_mme,
  output logic [2:0] r_mme,
  output logic [1:0] grant,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_MAR  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_OUT  = 3'd3,
    S_LD_MDR  = 3'd4,
    S_WR_WAIT = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             r_owner_data;  // 1: data requester owns MAR/MDR, 0: fetch
  logic             r_we;          // latched store flag for the current access
  logic [CNT_W-1:0] r_cnt;         // cycles spent in the current wait state
  logic             w_pick_data;
  logic             w_any_req;
  logic             w_tmo;
  logic             w_ack;

  assign w_any_req = fetch_req | data_req;
  // Timeout fires one cycle after TIMEOUT_CYCLES wait cycles have elapsed.
  assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

`ifdef MEM_ARB_RR_EN
  logic r_last_data;  // 1: data was served last, 0: fetch was served last

  // Round robin: on a tie, the requester not served last wins.
  always_comb begin
    w_pick_data = data_req & (~fetch_req | ~r_last_data);
  end

  // Remember who finished last (ack or timeout abort).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_data <= 1'b0;
    end else if (w_ack || err) begin
      r_last_data <= r_owner_data;
    end
  end
`else
  // Fixed priority: data over fetch.
  always_comb begin
    w_pick_data = data_req;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Latch owner and direction at grant; run the wait-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_data <= 1'b0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_owner_data <= w_pick_data;
        r_we         <= w_pick_data & data_we;
      end
      if (r_state == S_RD_WAIT || r_state == S_WR_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Next-state logic and per-state select codes, strobes and pulses.
  always_comb begin
    w_state_next = r_state;
    w_mme        = 3'b000;
    r_mme        = 3'b000;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    w_ack        = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_state_next = S_LD_MAR;
        end
      end
      S_LD_MAR: begin
        w_mme        = 3'b100;
        w_state_next = r_we ? S_LD_MDR : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_mme = 3'b001;
        r_mme = 3'b100;
        if (w_tmo) begin
          err          = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            w_state_next = S_RD_OUT;
          end
        end
      end
      S_RD_OUT: begin
        r_mme        = 3'b010;
        w_ack        = 1'b1;
        w_state_next = S_IDLE;
      end
      S_LD_MDR: begin
        w_mme        = 3'b010;
        r_mme        = 3'b100;
        w_state_next = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        r_mme = 3'b001;
        if (w_tmo) begin
          err          = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          mem_wr = 1'b1;
          if (mem_ready) begin
            w_ack        = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Ownership and activity flags derived from state and latched owner.
  always_comb begin
    busy      = (r_state != S_IDLE);
    grant     = busy ? (r_owner_data ? 2'b10 : 2'b01) : 2'b00;
    fetch_ack = w_ack & ~r_owner_data;
    data_ack  = w_ack & r_owner_data;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a cycle-scheduled driver computes each
// transaction's timeline from the access rules (latency, wait cycles,
// timeout), pushes the expected ack/err event into a scoreboard queue and
// publishes the expected per-cycle codes; a negedge monitor compares.
module tb_mem_access_ctrl;
  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0, mem_ready = 1'b0;
  logic       fetch_ack, data_ack, mem_rd, mem_wr, busy, err;
  logic [2:0] w_mme, r_mme;
  logic [1:0] grant;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_we(data_we), .data_ack(data_ack),
    .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .w_mme(w_mme), .r_mme(r_mme), .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int at; bit is_err; bit fe; } exp_t;
  exp_t sbq[$];

  bit         exp_valid = 1'b0;
  logic [2:0] exp_w = '0, exp_r = '0;
  logic       exp_rd = 1'b0, exp_wr = 1'b0, exp_busy = 1'b0;
  logic [1:0] exp_grant = '0;
  bit         last_fetch = 1'b1;  // arbitration history: fetch served last
  bit         allow_drop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic set_idle_exp();
    exp_valid = 1'b1;
    exp_w = '0; exp_r = '0; exp_rd = 1'b0; exp_wr = 1'b0;
    exp_busy = 1'b0; exp_grant = '0;
  endtask

  // Monitor: per-cycle code checks plus scoreboard pop on each ack/err.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("w_mme", w_mme, exp_w);
      chk("r_mme", r_mme, exp_r);
      chk("mem_rd", mem_rd, exp_rd);
      chk("mem_wr", mem_wr, exp_wr);
      chk("busy", busy, exp_busy);
      chk("grant", grant, exp_grant);
    end
    if (cyc > 0 && !rst) begin
      chk("mdr_excl", ((w_mme[1] | w_mme[0]) & (r_mme[1] | r_mme[0])), 0);
      chk("mar_excl", (w_mme[2] & r_mme[2]), 0);
    end
    if (fetch_ack === 1'b1 || data_ack === 1'b1 || err === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event cycle %0d: fetch_ack=%b data_ack=%b err=%b, expected none",
                 cyc, fetch_ack, data_ack, err);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("event_cycle", cyc, e.at);
        chk("fetch_ack", fetch_ack, (!e.is_err && e.fe));
        chk("data_ack", data_ack, (!e.is_err && !e.fe));
        chk("err", err, e.is_err);
      end
    end
  end

  function automatic bit winner_is_fetch(input bit f, input bit d);
    if (!d) return 1'b1;
    if (!f) return 1'b0;
`ifdef MEM_ARB_RR_EN
    return !last_fetch;
`else
    return 1'b0;
`endif
  endfunction

  // Drive one granted access whose arbitration cycle is c0. k = wait cycle
  // in which mem_ready rises (1-based), k = 0 means memory never answers.
  task automatic serve(input bit fe, input bit we, input int k, input int c0, output int e);
    bit rd;
    int w0, rdy;
    rd  = fe || !we;
    w0  = c0 + (rd ? 2 : 3);
    rdy = (k > 0) ? (w0 + k - 1) : -1;
    e   = (k > 0) ? (rd ? rdy + 1 : rdy) : (w0 + TO);
    sbq.push_back('{at: e, is_err: (k == 0), fe: fe});
    for (int c = c0 + 1; c <= e; c++) begin
      @(posedge clk); #1;
      exp_valid = 1'b1; exp_busy = 1'b1; exp_grant = fe ? 2'b01 : 2'b10;
      exp_rd = 1'b0; exp_wr = 1'b0;
      if (c == c0 + 1) begin
        exp_w = 3'b100; exp_r = 3'b000;
      end else if (c < w0) begin
        exp_w = 3'b010; exp_r = 3'b100;
      end else if (rd && k > 0 && c == e) begin
        exp_w = 3'b000; exp_r = 3'b010;
      end else begin
        exp_w  = rd ? 3'b001 : 3'b000;
        exp_r  = rd ? 3'b100 : 3'b001;
        exp_rd = rd && !(k == 0 && c == e);
        exp_wr = !rd && !(k == 0 && c == e);
      end
      // mem_ready noise outside wait cycles must be ignored.
      mem_ready = (c == rdy) || ((c < w0 || (rd && k > 0 && c == e)) && ($urandom_range(0, 1) == 1));
      data_we = 1'($urandom_range(0, 1));
      if (allow_drop && c < e && $urandom_range(0, 7) == 0) begin
        if (fe) fetch_req = 1'b0; else data_req = 1'b0;
      end
    end
    @(posedge clk); #1;
    if (fe) fetch_req = 1'b0; else data_req = 1'b0;
    mem_ready = 1'b0;
    set_idle_exp();
    last_fetch = fe;
  endtask

  // One arbitration round; with both requests the loser either follows up
  // (keeps its request) or withdraws when the winner finishes.
  task automatic txn(input bit f, input bit d, input bit we, input int k1, input int k2,
                     input bit follow, input bit we2);
    int  e, c0;
    bit  wf;
    fetch_req = f; data_req = d; data_we = we; c0 = cyc;
    wf = winner_is_fetch(f, d);
    serve(wf, we, k1, c0, e);
    if (f && d) begin
      if (follow) begin
        data_we = we2;
        serve(!wf, we2, k2, cyc, e);
      end else begin
        fetch_req = 1'b0; data_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    rst = 1'b1; fetch_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    set_idle_exp();
    @(posedge clk); #1;
    rst = 1'b0;
    last_fetch = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("reset_busy", busy, 0);
    chk("reset_err", err, 0);

    // Fetch read, mem_ready on first wait cycle.
    txn(1'b1, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0);
    // Store with mem_ready in the 4th wait cycle.
    txn(1'b0, 1'b1, 1'b1, 4, 0, 1'b0, 1'b0);

    // Simultaneous requests three times from a fresh arbitration state.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1 + $urandom_range(0, 2), 0, 1'b0, 1'b0);
    end

    // Load that never sees mem_ready.
    txn(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reset while in RD_WAIT, then a fresh fetch.
    fetch_req = 1'b1;
    exp_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; fetch_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle_exp();
    last_fetch = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0);

    // Randomized traffic.
    allow_drop = 1'b1;
    for (int i = 0; i < 150; i++) begin
      int  sel, k1, k2, gap;
      sel = $urandom_range(1, 3);
      k1  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      k2  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      txn(sel[0], sel[1], 1'($urandom_range(0, 1)), k1, k2,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      mem_ready = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer for the MAR/MDR pair in the RSC chip. It arbitrates between an instruction-fetch requester and a data (load/store) requester.
- For the granted request it drives the 3-bit write/read select codes for MAR/MDR and the memory read/write strobes.
- It handshakes with memory through mem_ready, and a timeout counter reports a memory that never responds.

Parameters:
- TIMEOUT_CYCLES, 15: maximum cycles spent waiting on mem_ready before abort (1..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  instruction fetch request (always a read); held until fetch_ack
- fetch_ack  out  1  one-cycle pulse; fetch data is valid on the bus this cycle
- data_req  in  1  data access request; held until data_ack or err
- data_we  in  1  with data_req: 1 = store, 0 = load; sampled at grant
- data_ack  out  1  one-cycle pulse on load data valid or store complete
- mem_ready  in  1  memory has completed the current read/write
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- w_mme  out  3  write select: 100 bus->MAR, 010 bus->MDR, 001 memory->MDR, 000 none
- r_mme  out  3  read select: 100 MAR->address, 010 MDR->bus, 001 MDR->memory, 000 none
- grant  out  2  01 fetch owns MAR/MDR, 10 data owns it, 00 idle
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state=IDLE; every output 0; timeout counter 0; round-robin pointer = fetch-last.
- In IDLE, w_mme=r_mme=000.
- States and codes (w_mme/r_mme):
  - IDLE: arbitrate; on any request latch the owner and we, then go to LD_MAR.
  - LD_MAR (100/000): one cycle. Next is RD_WAIT for a read, LD_MDR for a write.
  - RD_WAIT (001/100): mem_rd=1. On mem_ready go to RD_OUT.
  - RD_OUT (000/010): owner's ack=1 for exactly this cycle, then IDLE.
  - LD_MDR (010/100): one cycle; MAR is driven to the address. Next is WR_WAIT.
  - WR_WAIT (000/001): mem_wr=1. On mem_ready, owner's ack=1 in the same cycle, then IDLE.
- w_mme and r_mme never both select MDR in the same cycle, and never both select MAR.
- Latency, mem_ready asserted on the first wait cycle:
  - read: ack 3 cycles after grant;
  - write: ack 3 cycles after grant.
- Each wait cycle without mem_ready adds one cycle.
- grant holds its value from LD_MAR through the ack cycle; it is 00 in IDLE.
- Arbitration (default): fixed priority, data over fetch. With both requests in the same IDLE cycle, data wins.
- A requester deasserting req mid-transaction is ignored; the transaction completes.
- Timeout:
  - The counter clears on entry to RD_WAIT/WR_WAIT and increments each wait cycle.
  - On reaching TIMEOUT_CYCLES without mem_ready: err=1 for one cycle, no ack, strobes drop, state goes to IDLE.
  - The requester must then drop req or it is re-arbitrated.
- mem_ready outside RD_WAIT/WR_WAIT is ignored.
- rst mid-transaction: next edge forces IDLE; no ack, no err; strobes low.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. With both requests present, the requester not served last wins. The pointer updates on each ack or err.
- Undefined: fixed data>fetch priority; no pointer register.

Test Plan:
- Fetch read, mem_ready on first wait cycle:
  - codes LD_MAR 100/000 -> RD_WAIT 001/100 mem_rd=1 -> RD_OUT 000/010;
  - fetch_ack 3 cycles after request, grant=01 throughout.
- Store, data_we=1, mem_ready after 4 wait cycles:
  - LD_MAR 100/000 -> LD_MDR 010/100 -> WR_WAIT 000/001 with mem_wr=1 for 4 cycles;
  - data_ack in the 4th wait cycle; err=0.
- fetch_req and data_req together, repeated 3 times:
  - default: grant=10 all three times;
  - MEM_ARB_RR_EN: grants 10, 01, 10.
- Load with mem_ready never asserted, TIMEOUT_CYCLES=15: err pulses after 15 RD_WAIT cycles; no data_ack; busy=0 the next cycle.
- rst asserted during RD_WAIT: next cycle all outputs 0, state IDLE; a fresh fetch then completes normally.
- Per-cycle assertion over all tests: never (w_mme=010|001 with r_mme=010|001), never (w_mme=100 with r_mme=100).
